mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between instruction fetch (IF) and the MEM-stage load/store path, which is driven by mem_read/mem_write from the main decoder.
- Sequences each transaction with a req/ack handshake to a variable-latency memory.
- Returns data to the requester and produces per-stage stall signals for the pipeline hazard logic.
- Detects memory that never acknowledges.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width (byte enables are DATA_W/8 bits).
- TIMEOUT, 64, cycles without mem_ack before a transaction is aborted (≥2).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- if_req  in  1  fetch request, held until if_ready
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched instruction
- if_ready  out  1  one-cycle completion pulse, fetch
- dm_read  in  1  load request (decoder mem_read)
- dm_write  in  1  store request (decoder mem_write)
- dm_addr  in  ADDR_W  load/store address
- dm_wdata  in  DATA_W  store data
- dm_be  in  DATA_W/8  store byte enables
- dm_rdata  out  DATA_W  load data
- dm_ready  out  1  one-cycle completion pulse, data
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_be  out  DATA_W/8  memory byte enables (all ones on reads)
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack
- mem_ack  in  1  one-cycle completion from memory
- stall_if  out  1  = if_req & ~if_ready (combinational)
- stall_mem  out  1  = (dm_read|dm_write) & ~dm_ready (combinational)
- err  out  1  one-cycle timeout pulse

Behaviour:
- Reset (synchronous, dominant over all other inputs):
  - Goes to IDLE.
  - Zeroes the following: mem_req, mem_we, mem_addr, mem_wdata, mem_be, if_rdata, dm_rdata, if_ready, dm_ready, err, timeout counter.
  - Sets last_grant = IF.
  - A mem_ack arriving after reset, in IDLE, is ignored.
- FSM has three states: IDLE, DATA_BUSY, INST_BUSY.
- Arbitration, evaluated in IDLE and in the ack cycle of a busy state:
  - Only one pending requester: grant it.
  - Both pending: grant the requester not granted last (last_grant register). After reset with both pending, DATA wins.
  - Pending means the request is high and that requester is not being completed in this same cycle.
- Grant at edge N:
  - mem_req=1 from cycle N+1.
  - mem_addr/mem_we/mem_wdata/mem_be are registered from the requester at N and held constant until ack.
  - Goes to the matching BUSY state and updates last_grant.
- dm_read and dm_write both high: treated as a write.
- In a BUSY state, mem_ack high at edge M:
  - Capture mem_rdata into the granted requester's rdata register (writes leave dm_rdata unchanged).
  - Pulse that requester's ready at M+1.
  - Re-arbitrate at M. With a pending request, mem_req stays high and the new address appears at M+1 (back-to-back, no bubble). Otherwise go to IDLE with mem_req=0.
- rdata registers hold their value until the next completion for that requester.
- Minimum latency: request seen at edge N, mem_ack at N+1, ready at N+2.
- Timeout counter:
  - Clears on grant; increments each BUSY cycle without ack.
  - On reaching TIMEOUT-1 with no ack: pulse err, drop mem_req, go to IDLE, do not pulse ready. The requester stays stalled and is re-arbitrated.
  - An ack in the same cycle as the timeout takes precedence: normal completion, no err.
- A request deasserted before grant is dropped. A request deasserted after grant does not cancel: the transaction completes and ready still pulses.
- mem_ack in IDLE is ignored.

Decomposition:
- Shared package riscv_mem_pkg holds:
  - typedef enum arb_state_t {IDLE, DATA_BUSY, INST_BUSY}
  - typedef enum grant_t {GNT_IF, GNT_DATA}
  - constant BE_ALL, the all-ones byte enable
- One sub-module, mem_timeout_ctr: clear/enable inputs, expired output, parameter TIMEOUT. Instantiated once.

Test Plan:
- After reset, if_req=1 with if_addr=0x100; memory acks 2 cycles after mem_req with 0x00500093 -> mem_req rises the next cycle, mem_addr=0x100, mem_we=0; if_ready pulses once; if_rdata=0x00500093; stall_if high until the ready cycle.
- dm_write=1, dm_addr=0x2000, dm_wdata=0xDEADBEEF, dm_be=4'b0011 -> mem_we=1 and mem_be=4'b0011 held until ack; dm_ready pulses; dm_rdata unchanged.
- if_req and dm_read both high from reset, every request acked after 1 cycle -> grant order DATA, IF, DATA, IF; back-to-back with no idle cycle between mem_req phases.
- Memory never acks, TIMEOUT=8 -> err pulses 8 cycles after grant; mem_req drops; no ready pulse; request re-granted afterwards.
- Reset asserted in DATA_BUSY, then mem_ack arrives -> mem_req=0 the next cycle; ack ignored; no ready; rdata registers 0.
- mem_ack in the same cycle as the timeout expiry -> normal completion with ready pulse and no err.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the unified memory port arbiter.
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DATA_BUSY = 2'd1,
    INST_BUSY = 2'd2
  } arb_state_t;

  typedef enum logic {
    GNT_IF   = 1'b0,
    GNT_DATA = 1'b1
  } grant_t;

  // Wide enough for any supported data width; users slice the low DATA_W/8 bits.
  localparam logic [63:0] BE_ALL = '1;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Counts busy cycles without an acknowledge; expired flags the last allowed cycle.
module mem_timeout_ctr #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expired) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store with
// round-robin arbitration, back-to-back grants and an acknowledge timeout.
// Handshake: mem_req rises the cycle after a grant and holds with stable
// address/data until mem_ack is seen at a clock edge; the requester's ready
// pulses for exactly one cycle after that edge.
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ready,
  input  logic                dm_read,
  input  logic                dm_write,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_be,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack,
  output logic                stall_if,
  output logic                stall_mem,
  output logic                err
);

  localparam int BE_W = DATA_W / 8;

  arb_state_t        state_q, state_d;
  grant_t            last_grant_q, last_grant_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [BE_W-1:0]   mem_be_q, mem_be_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              if_ready_q, if_ready_d;
  logic              dm_ready_q, dm_ready_d;
  logic              err_q, err_d;

  logic   if_done, dm_done, if_pend, dm_pend;
  logic   arb_en, do_grant, busy, expired, timeout_hit;
  grant_t grant_sel;

  // A requester completing at this edge is not pending, so the other side
  // can be granted in the ack cycle without a bubble.
  always_comb begin
    busy        = (state_q != IDLE);
    if_done     = (state_q == INST_BUSY) && mem_ack;
    dm_done     = (state_q == DATA_BUSY) && mem_ack;
    if_pend     = if_req && !if_done;
    dm_pend     = (dm_read || dm_write) && !dm_done;
    arb_en      = (state_q == IDLE) || if_done || dm_done;
    do_grant    = arb_en && (if_pend || dm_pend);
    timeout_hit = busy && expired && !mem_ack;
    grant_sel   = GNT_IF;
    if (if_pend && dm_pend) begin
      grant_sel = (last_grant_q == GNT_IF) ? GNT_DATA : GNT_IF;
    end else if (dm_pend) begin
      grant_sel = GNT_DATA;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_be_d     = mem_be_q;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    if_ready_d   = 1'b0;
    dm_ready_d   = 1'b0;
    err_d        = 1'b0;

    if (if_done) begin
      if_rdata_d = mem_rdata;
      if_ready_d = 1'b1;
    end
    if (dm_done) begin
      if (!mem_we_q) dm_rdata_d = mem_rdata;
      dm_ready_d = 1'b1;
    end

    if (timeout_hit) begin
      err_d     = 1'b1;
      mem_req_d = 1'b0;
      state_d   = IDLE;
    end else if (arb_en) begin
      if (do_grant) begin
        mem_req_d    = 1'b1;
        last_grant_d = grant_sel;
        if (grant_sel == GNT_DATA) begin
          state_d     = DATA_BUSY;
          mem_we_d    = dm_write;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          mem_be_d    = dm_write ? dm_be : BE_ALL[BE_W-1:0];
        end else begin
          state_d     = INST_BUSY;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          mem_be_d    = BE_ALL[BE_W-1:0];
        end
      end else begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_IF;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= '0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
      if_ready_q   <= 1'b0;
      dm_ready_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_be_q     <= mem_be_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
      if_ready_q   <= if_ready_d;
      dm_ready_q   <= dm_ready_d;
      err_q        <= err_d;
    end
  end

  mem_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (do_grant),
    .enable  (busy),
    .expired (expired)
  );

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_ready  = if_ready_q;
  assign dm_ready  = dm_ready_q;
  assign err       = err_q;
  assign stall_if  = if_req && !if_ready_q;
  assign stall_mem = (dm_read || dm_write) && !dm_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table for round-robin
// back-to-back traffic plus hand-written multi-cycle sequences.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        dm_read;
  logic        dm_write;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic [31:0] dm_rdata;
  logic        dm_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        stall_if;
  logic        stall_mem;
  logic        err;

  int tests_run = 0;
  int tests_failed = 0;

  mem_port_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ready  (if_ready),
    .dm_read   (dm_read),
    .dm_write  (dm_write),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_be     (dm_be),
    .dm_rdata  (dm_rdata),
    .dm_ready  (dm_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .stall_if  (stall_if),
    .stall_mem (stall_mem),
    .err       (err)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog expired");
  end

  // Per-cycle vector: inputs for the cycle, then expected outputs in it.
  typedef struct {
    logic        i_if_req;
    logic        i_dm_read;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_if_ready;
    logic        e_dm_ready;
    logic        e_stall_if;
    logic        e_stall_mem;
    logic [31:0] e_if_rdata;
    logic [31:0] e_dm_rdata;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    if_req    = 1'b0;
    if_addr   = 32'h0;
    dm_read   = 1'b0;
    dm_write  = 1'b0;
    dm_addr   = 32'h0;
    dm_wdata  = 32'h0;
    dm_be     = 4'h0;
    mem_rdata = 32'h0;
    mem_ack   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    check("rst mem_req", {31'b0, mem_req}, 32'h0);
    check("rst mem_we", {31'b0, mem_we}, 32'h0);
    check("rst mem_addr", mem_addr, 32'h0);
    check("rst mem_wdata", mem_wdata, 32'h0);
    check("rst mem_be", {28'b0, mem_be}, 32'h0);
    check("rst if_rdata", if_rdata, 32'h0);
    check("rst dm_rdata", dm_rdata, 32'h0);
    check("rst if_ready", {31'b0, if_ready}, 32'h0);
    check("rst dm_ready", {31'b0, dm_ready}, 32'h0);
    check("rst err", {31'b0, err}, 32'h0);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    #1;
    do_reset();

    // Single fetch, memory acks two cycles after mem_req rises
    if_req  = 1'b1;
    if_addr = 32'h100;
    #1;
    check("f1 idle req", {31'b0, mem_req}, 32'h0);
    check("f1 idle stall", {31'b0, stall_if}, 32'h1);
    tick();
    check("f1 req", {31'b0, mem_req}, 32'h1);
    check("f1 addr", mem_addr, 32'h100);
    check("f1 we", {31'b0, mem_we}, 32'h0);
    check("f1 be", {28'b0, mem_be}, 32'hF);
    check("f1 stall", {31'b0, stall_if}, 32'h1);
    tick();
    check("f1 req hold", {31'b0, mem_req}, 32'h1);
    check("f1 no ready", {31'b0, if_ready}, 32'h0);
    check("f1 stall hold", {31'b0, stall_if}, 32'h1);
    mem_ack   = 1'b1;
    mem_rdata = 32'h00500093;
    tick();
    check("f1 ready", {31'b0, if_ready}, 32'h1);
    check("f1 rdata", if_rdata, 32'h00500093);
    check("f1 stall off", {31'b0, stall_if}, 32'h0);
    check("f1 req drop", {31'b0, mem_req}, 32'h0);
    if_req  = 1'b0;
    mem_ack = 1'b0;
    tick();
    check("f1 ready once", {31'b0, if_ready}, 32'h0);
    check("f1 idle after", {31'b0, mem_req}, 32'h0);

    // Both requesters from reset, each request acked after one cycle
    vecs[0] = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 1'b1, 32'h0,        32'h0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 32'hAAAA0001, 1'b1, 32'h2000, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0,        32'h0};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 32'hBBBB0002, 1'b1, 32'h100,  1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        32'hAAAA0001};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 32'hCCCC0003, 1'b1, 32'h2000, 1'b1, 1'b0, 1'b0, 1'b1, 32'hBBBB0002, 32'hAAAA0001};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 32'hDDDD0004, 1'b1, 32'h100,  1'b0, 1'b1, 1'b1, 1'b0, 32'hBBBB0002, 32'hCCCC0003};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,    1'b1, 1'b0, 1'b0, 1'b0, 32'hDDDD0004, 32'hCCCC0003};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 32'hEEEE0005, 1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 1'b0, 32'hDDDD0004, 32'hCCCC0003};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 1'b0, 32'hDDDD0004, 32'hCCCC0003};

    idle_inputs();
    do_reset();
    if_addr = 32'h100;
    dm_addr = 32'h2000;
    for (int i = 0; i < 8; i++) begin
      if_req    = vecs[i].i_if_req;
      dm_read   = vecs[i].i_dm_read;
      mem_ack   = vecs[i].i_ack;
      mem_rdata = vecs[i].i_rdata;
      #1;
      check($sformatf("v%0d mem_req", i), {31'b0, mem_req}, {31'b0, vecs[i].e_req});
      if (vecs[i].e_req) begin
        check($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].e_addr);
        check($sformatf("v%0d mem_we", i), {31'b0, mem_we}, 32'h0);
      end
      check($sformatf("v%0d if_ready", i), {31'b0, if_ready}, {31'b0, vecs[i].e_if_ready});
      check($sformatf("v%0d dm_ready", i), {31'b0, dm_ready}, {31'b0, vecs[i].e_dm_ready});
      check($sformatf("v%0d stall_if", i), {31'b0, stall_if}, {31'b0, vecs[i].e_stall_if});
      check($sformatf("v%0d stall_mem", i), {31'b0, stall_mem}, {31'b0, vecs[i].e_stall_mem});
      check($sformatf("v%0d if_rdata", i), if_rdata, vecs[i].e_if_rdata);
      check($sformatf("v%0d dm_rdata", i), dm_rdata, vecs[i].e_dm_rdata);
      check($sformatf("v%0d err", i), {31'b0, err}, 32'h0);
      tick();
    end
    idle_inputs();

    // Store: attributes held until ack, dm_rdata untouched
    dm_write = 1'b1;
    dm_addr  = 32'h2000;
    dm_wdata = 32'hDEADBEEF;
    dm_be    = 4'b0011;
    #1;
    check("st stall", {31'b0, stall_mem}, 32'h1);
    tick();
    check("st req", {31'b0, mem_req}, 32'h1);
    check("st we", {31'b0, mem_we}, 32'h1);
    check("st addr", mem_addr, 32'h2000);
    check("st wdata", mem_wdata, 32'hDEADBEEF);
    check("st be", {28'b0, mem_be}, 32'h3);
    dm_wdata = 32'h0;
    dm_be    = 4'hF;
    dm_addr  = 32'h0;
    tick();
    tick();
    check("st wdata hold", mem_wdata, 32'hDEADBEEF);
    check("st be hold", {28'b0, mem_be}, 32'h3);
    check("st addr hold", mem_addr, 32'h2000);
    check("st we hold", {31'b0, mem_we}, 32'h1);
    mem_ack   = 1'b1;
    mem_rdata = 32'h55555555;
    tick();
    check("st ready", {31'b0, dm_ready}, 32'h1);
    check("st rdata kept", dm_rdata, 32'hCCCC0003);
    check("st stall off", {31'b0, stall_mem}, 32'h0);
    dm_write = 1'b0;
    mem_ack  = 1'b0;
    tick();
    check("st ready once", {31'b0, dm_ready}, 32'h0);
    check("st idle", {31'b0, mem_req}, 32'h0);

    // No ack: err 8 cycles after grant, then re-grant
    if_req  = 1'b1;
    if_addr = 32'h300;
    tick();
    check("to req", {31'b0, mem_req}, 32'h1);
    for (int k = 1; k < 8; k++) begin
      tick();
      check($sformatf("to wait%0d err", k), {31'b0, err}, 32'h0);
      check($sformatf("to wait%0d req", k), {31'b0, mem_req}, 32'h1);
    end
    tick();
    check("to err", {31'b0, err}, 32'h1);
    check("to req drop", {31'b0, mem_req}, 32'h0);
    check("to no ready", {31'b0, if_ready}, 32'h0);
    check("to stall", {31'b0, stall_if}, 32'h1);
    tick();
    check("to err once", {31'b0, err}, 32'h0);
    check("to regrant", {31'b0, mem_req}, 32'h1);
    check("to regrant addr", mem_addr, 32'h300);

    // Ack in the expiry cycle completes normally
    for (int k = 1; k < 8; k++) begin
      tick();
      check($sformatf("ta wait%0d err", k), {31'b0, err}, 32'h0);
    end
    mem_ack   = 1'b1;
    mem_rdata = 32'h0BADF00D;
    tick();
    check("ta ready", {31'b0, if_ready}, 32'h1);
    check("ta no err", {31'b0, err}, 32'h0);
    check("ta rdata", if_rdata, 32'h0BADF00D);
    if_req  = 1'b0;
    mem_ack = 1'b0;
    tick();
    check("ta after err", {31'b0, err}, 32'h0);
    check("ta after req", {31'b0, mem_req}, 32'h0);

    // Reset while DATA_BUSY, then a late ack
    dm_read = 1'b1;
    dm_addr = 32'h40;
    tick();
    check("rb req", {31'b0, mem_req}, 32'h1);
    reset   = 1'b1;
    dm_read = 1'b0;
    tick();
    check("rb req off", {31'b0, mem_req}, 32'h0);
    check("rb if_rdata", if_rdata, 32'h0);
    check("rb dm_rdata", dm_rdata, 32'h0);
    reset     = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 32'h12345678;
    tick();
    check("rb no ready", {31'b0, dm_ready}, 32'h0);
    check("rb no if ready", {31'b0, if_ready}, 32'h0);
    check("rb req idle", {31'b0, mem_req}, 32'h0);
    check("rb rdata zero", dm_rdata, 32'h0);
    mem_ack = 1'b0;
    tick();
    check("rb still no ready", {31'b0, dm_ready}, 32'h0);
    check("rb no err", {31'b0, err}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
